slow_mem_responder: RTL

Memory-side responder for the cache-to-memory line interface used by the D-cache and I-cache. It accepts one 128-bit line read or write from a cache, waits a programmable number of cycles, then completes the transfer with a one-cycle mem_ready pulse. It replaces the fixed-latency slow_memD/slow_memI models in synthesizable system builds and in benches. It holds the lines in an internal array.

---
 rtl/slow_mem_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/slow_mem_responder.sv
// Programmable-latency line memory responder for the cache-to-memory interface.
// Optional SLOW_MEM_STATS_EN adds saturating completed-read/write counters.
module slow_mem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         proto_err
`ifdef SLOW_MEM_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_cnt;
  logic                   r_is_wr;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [127:0]           r_wdata;
  logic [127:0]           r_rdata;
  logic                   r_perr;
  logic [127:0]           r_mem [2**ADDR_BITS];

  logic                   w_accept;
  logic                   w_load_rd;
  logic [ADDR_BITS-1:0]   w_rd_idx;
  logic                   w_addr_unused;

  assign w_accept      = (r_state == S_IDLE) && (mem_read || mem_write);
  assign w_addr_unused = ^mem_addr[27:ADDR_BITS];

  // Read data is captured on the edge entering RESP; with LATENCY=1 that is
  // the acceptance edge itself, so the live request fields are used.
  always_comb begin
    w_load_rd = 1'b0;
    w_rd_idx  = r_idx;
    if (w_accept && LATENCY == 1 && !mem_write) begin
      w_load_rd = 1'b1;
      w_rd_idx  = mem_addr[ADDR_BITS-1:0];
    end else if (r_state == S_WAIT && r_cnt == 8'd1 && !r_is_wr) begin
      w_load_rd = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 8'd1) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_is_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_is_wr <= mem_write;
        r_idx   <= mem_addr[ADDR_BITS-1:0];
        r_wdata <= mem_wdata;
        r_cnt   <= 8'(LATENCY - 1);
        if (mem_read && mem_write) r_perr <= 1'b1;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_load_rd) r_rdata <= r_mem[w_rd_idx];
    end
  end

  // Array contents survive reset; only the pending write is suppressed.
  always_ff @(posedge clk) begin
    if (!proc_reset && r_state == S_RESP && r_is_wr) r_mem[r_idx] <= r_wdata;
  end

`ifdef SLOW_MEM_STATS_EN
  logic [15:0] r_rd_cnt, r_wr_cnt;
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_rd_cnt <= 16'd0;
      r_wr_cnt <= 16'd0;
    end else if (r_state == S_RESP) begin
      if (r_is_wr && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (!r_is_wr && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end
  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;
`endif

  assign mem_rdata = r_rdata;
  assign mem_ready = (r_state == S_RESP);
  assign proto_err = r_perr;

endmodule
